// File: rtl/alu_pkg.sv
// Shared ALU/MDU definitions: operation codes, ALUOp
// classes, Funct7 patterns and the MDU sequencer state.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  // Funct3 to ALU op for plain R/I arithmetic.
  function automatic logic [3:0] base_op(
    input logic [2:0] f3
  );
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode: operation code,
// illegal-encoding flag and RV32M detection.
module alu_decode
  import alu_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic       valid_in,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  output logic [3:0] Operation,
  output logic       illegal,
  output logic       mop
);

  logic alt;
  logic base;
  logic bad;

  // Operation / legality per ALUOp class.
  always_comb begin
    alt  = (Funct7 == F7_ALT);
    base = (Funct7 == F7_BASE);
    mop  = (ENABLE_M != 0) && (ALUOp == ALUOP_R)
        && (Funct7 == F7_MULDIV);
    Operation = OP_ADD;
    bad  = 1'b0;
    case (ALUOp)
      ALUOP_MEM: Operation = OP_ADD;
      ALUOP_BR: begin
        case (Funct3[2:1])
          2'b10:   Operation = OP_SLT;
          2'b11:   Operation = OP_SLTU;
          default: Operation = OP_SUB;
        endcase
      end
      ALUOP_R: begin
        if (mop)
          Operation = OP_ADD;
        else if (alt && Funct3 == 3'b000)
          Operation = OP_SUB;
        else if (alt && Funct3 == 3'b101)
          Operation = OP_SRA;
        else
          Operation = base_op(Funct3);
        bad = !(base || alt || mop)
           || (alt && Funct3 != 3'b000
                   && Funct3 != 3'b101);
      end
      default: begin
        if (alt && Funct3 == 3'b101)
          Operation = OP_SRA;
        else
          Operation = base_op(Funct3);
        bad = (Funct3 == 3'b001 && !base)
           || (Funct3 == 3'b101 && !(base || alt));
      end
    endcase
    illegal = valid_in & bad;
  end

endmodule

// File: rtl/alu_mdu_controller.sv
// ALU control plus multi-cycle MUL/DIV sequencer:
// accept in IDLE, count LAT cycles in BUSY, pulse DONE.
module alu_mdu_controller
  import alu_pkg::*;
#(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       flush,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  output logic [3:0] Operation,
  output logic [2:0] mdu_op,
  output logic       mdu_start,
  output logic       mdu_sel,
  output logic       stall,
  output logic       done,
  output logic       illegal
);

  localparam int MAXL =
    (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW =
    (MAXL <= 1) ? 1 : $clog2(MAXL);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

  mdu_state_e    state;
  mdu_state_e    nstate;
  logic [CW-1:0] cnt;
  logic          mop;
  logic          accept;

  alu_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .valid_in  (valid_in),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .Operation (Operation),
    .illegal   (illegal),
    .mop       (mop)
  );

  assign accept = (state == S_IDLE) & valid_in
                & mop & ~flush & ~reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  // Latency counter and latched MDU function.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mdu_op <= 3'b000;
    end else if (accept) begin
      cnt    <= Funct3[2] ? DIV_LD : MUL_LD;
      mdu_op <= Funct3;
    end else if (flush) begin
      cnt    <= '0;
    end else if (state == S_BUSY && cnt != '0) begin
      cnt    <= cnt - CW'(1);
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    nstate = state;
    if (flush) begin
      nstate = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (accept) nstate = S_BUSY;
        S_BUSY: if (cnt == '0) nstate = S_DONE;
        S_DONE: nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    mdu_start = accept;
    stall     = 1'b0;
    done      = 1'b0;
    mdu_sel   = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        (state == S_IDLE): stall = accept;
        (state == S_BUSY): stall = 1'b1;
        (state == S_DONE): begin
          done    = ~flush;
          mdu_sel = ~flush;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed bench for alu_mdu_controller: decode vectors
// and MUL/DIV sequencing with flush and reset aborts.
module tb_alu_mdu_controller;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic       flush;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;

  logic [3:0] Operation;
  logic [2:0] mdu_op;
  logic       mdu_start;
  logic       mdu_sel;
  logic       stall;
  logic       done;
  logic       illegal;

  logic [3:0] nm_Operation;
  logic [2:0] nm_mdu_op;
  logic       nm_mdu_start;
  logic       nm_mdu_sel;
  logic       nm_stall;
  logic       nm_done;
  logic       nm_illegal;

  int errors = 0;
  int checks = 0;
  int ndone;

  alu_mdu_controller #(
    .ENABLE_M (1),
    .MUL_LAT  (2),
    .DIV_LAT  (32)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .flush     (flush),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .Operation (Operation),
    .mdu_op    (mdu_op),
    .mdu_start (mdu_start),
    .mdu_sel   (mdu_sel),
    .stall     (stall),
    .done      (done),
    .illegal   (illegal)
  );

  alu_mdu_controller #(
    .ENABLE_M (0),
    .MUL_LAT  (2),
    .DIV_LAT  (32)
  ) u_nom (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .flush     (flush),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .Operation (nm_Operation),
    .mdu_op    (nm_mdu_op),
    .mdu_start (nm_mdu_start),
    .mdu_sel   (nm_mdu_sel),
    .stall     (nm_stall),
    .done      (nm_done),
    .illegal   (nm_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic       v,
    input logic [1:0] a,
    input logic [6:0] f7,
    input logic [2:0] f3
  );
    valid_in = v;
    ALUOp    = a;
    Funct7   = f7;
    Funct3   = f3;
  endtask

  task automatic vec(
    input string      tag,
    input logic       v,
    input logic [1:0] a,
    input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [3:0] eop,
    input logic       eill
  );
    @(posedge clk); #1;
    drive(v, a, f7, f3);
    @(negedge clk);
    chk({tag, "_op"}, Operation, eop);
    chk({tag, "_ill"}, illegal, eill);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_start"}, mdu_start, 1'b0);
  endtask

  task automatic run_mop(
    input logic [2:0] f3,
    input int         lat,
    input bit         hold
  );
    for (int c = 0; c <= lat + 2; c++) begin
      @(posedge clk); #1;
      if (c == 0)
        drive(1'b1, 2'b10, 7'b0000001, f3);
      else if (!hold || c == lat + 2)
        valid_in = 1'b0;
      @(negedge clk);
      chk("m_start", mdu_start, c == 0);
      chk("m_stall", stall, c <= lat);
      chk("m_done", done, c == lat + 1);
      chk("m_sel", mdu_sel, c == lat + 1);
      if (c == 0) begin
        chk("nm_ill", nm_illegal, 1'b1);
        chk("nm_stall", nm_stall, 1'b0);
        chk("nm_start", nm_mdu_start, 1'b0);
      end
      if (c == lat + 1)
        chk("m_op", mdu_op, f3);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 2'b00, 7'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_start", mdu_start, 1'b0);
    chk("rst_sel", mdu_sel, 1'b0);
    chk("rst_op", mdu_op, 3'b000);

    vec("ld", 1, 2'b00, 7'b0100000, 3'b010, 4'b0010, 0);
    vec("rsub", 1, 2'b10, 7'b0100000, 3'b000, 4'b0110, 0);
    vec("rsra", 1, 2'b10, 7'b0100000, 3'b101, 4'b1010, 0);
    vec("ralt6", 1, 2'b10, 7'b0100000, 3'b110, 4'b0001, 1);
    vec("beq", 1, 2'b01, 7'b0000000, 3'b001, 4'b0110, 0);
    vec("blt", 1, 2'b01, 7'b0000000, 3'b100, 4'b0111, 0);
    vec("bltu", 1, 2'b01, 7'b0000000, 3'b111, 4'b1011, 0);
    vec("radd", 1, 2'b10, 7'b0000000, 3'b000, 4'b0010, 0);
    vec("rsll", 1, 2'b10, 7'b0000000, 3'b001, 4'b1000, 0);
    vec("rslt", 1, 2'b10, 7'b0000000, 3'b010, 4'b0111, 0);
    vec("rsltu", 1, 2'b10, 7'b0000000, 3'b011, 4'b1011, 0);
    vec("rxor", 1, 2'b10, 7'b0000000, 3'b100, 4'b1100, 0);
    vec("rsrl", 1, 2'b10, 7'b0000000, 3'b101, 4'b1001, 0);
    vec("ror", 1, 2'b10, 7'b0000000, 3'b110, 4'b0001, 0);
    vec("rand", 1, 2'b10, 7'b0000000, 3'b111, 4'b0000, 0);
    vec("rbadf7", 1, 2'b10, 7'b0000011, 3'b000, 4'b0010, 1);
    vec("isra", 1, 2'b11, 7'b0100000, 3'b101, 4'b1010, 0);
    vec("iaddi", 1, 2'b11, 7'b0100000, 3'b000, 4'b0010, 0);
    vec("isllbad", 1, 2'b11, 7'b0100000, 3'b001, 4'b1000, 1);
    vec("isrbad", 1, 2'b11, 7'b0000001, 3'b101, 4'b1001, 1);
    vec("inval", 0, 2'b11, 7'b0000001, 3'b101, 4'b1001, 0);
    vec("mopadd", 0, 2'b10, 7'b0000001, 3'b100, 4'b0010, 0);

    run_mop(3'b000, 2, 1'b0);
    run_mop(3'b100, 32, 1'b1);

    @(posedge clk); #1;
    drive(1'b1, 2'b10, 7'b0000001, 3'b100);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_blk_start", mdu_start, 1'b0);
    chk("fl_blk_stall", stall, 1'b0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_blk_after", stall, 1'b0);

    ndone = 0;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      drive(c == 0, 2'b10, 7'b0000001, 3'b101);
      flush = (c == 5);
      @(negedge clk);
      if (done) ndone++;
      if (c == 0) chk("fl_start", mdu_start, 1'b1);
      if (c == 5) chk("fl_done5", done, 1'b0);
      if (c == 6) chk("fl_idle6", stall, 1'b0);
    end
    chk("fl_nodone", ndone, 0);

    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      drive(c == 0, 2'b10, 7'b0000001, 3'b001);
      flush = (c == 3);
      @(negedge clk);
      if (c == 3) begin
        chk("fld_done", done, 1'b0);
        chk("fld_sel", mdu_sel, 1'b0);
      end
      if (c == 4) chk("fld_stall", stall, 1'b0);
    end

    ndone = 0;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      drive(c == 0, 2'b10, 7'b0000001, 3'b100);
      reset = (c == 5);
      @(negedge clk);
      if (done) ndone++;
      if (c == 1) chk("rb_op", mdu_op, 3'b100);
      if (c == 6) begin
        chk("rb_stall", stall, 1'b0);
        chk("rb_done", done, 1'b0);
        chk("rb_start", mdu_start, 1'b0);
        chk("rb_sel", mdu_sel, 1'b0);
        chk("rb_mop", mdu_op, 3'b000);
      end
    end
    chk("rb_nodone", ndone, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
